// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// mux select codes and the packed control-strobe bundle.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EX   = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_timeout;
    } ctrl_t;

    // Quiet bundle: no strobes, muxes parked at their FETCH settings.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c           = '0;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALUOP_ADD;
        c.pc_source = PCSRC_ALU;
        return c;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive memory-wait counter; hit flags the wait cycle that reaches WAIT_MAX.
module mc_wait_timer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of earlier wait cycles, so this cycle is wait number cnt+1.
    assign hit = en && (cnt == LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core with memory-ready stall and timeout.
// Optional feature: define MULTICYCLE_BNE_EN to decode bne through the BRANCH state.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] Opcode,
    input  logic       Mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       Branch_ne,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] State,
    output logic       Illegal_op,
    output logic       Mem_timeout
);

    state_e state;
    state_e state_nxt;
    ctrl_t  ctrl;
    logic   wait_st;
    logic   wait_en;
    logic   wait_clr;
    logic   wait_hit;
    logic   bne_flag;

    assign wait_st  = (state == ST_FETCH) || (state == ST_MEM_READ) || (state == ST_MEM_WRITE);
    assign wait_en  = wait_st && !Mem_ready;
    // A timeout in FETCH does not change state, so the hit itself must clear the count.
    assign wait_clr = wait_hit || (state_nxt != state);

    mc_wait_timer #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (wait_en),
        .clr   (wait_clr),
        .hit   (wait_hit)
    );

`ifdef MULTICYCLE_BNE_EN
    logic bne_q;

    // Remember whether the branch being executed is a bne.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bne_q <= 1'b0;
        end else if (state == ST_DECODE) begin
            bne_q <= (Opcode == OP_BNE);
        end
    end

    assign bne_flag = bne_q;
`else
    assign bne_flag = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        ctrl           = '0;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                if (Mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_nxt     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_SEXT_SH;
                case (Opcode)
                    OP_RTYPE:      state_nxt = ST_EXECUTE;
                    OP_LW, OP_SW:  state_nxt = ST_MEM_ADDR;
                    OP_BEQ:        state_nxt = ST_BRANCH;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:        state_nxt = ST_BRANCH;
`endif
                    OP_J:          state_nxt = ST_JUMP;
                    OP_ADDI:       state_nxt = ST_ADDI_EX;
                    default: begin
                        ctrl.illegal_op = 1'b1;
                        state_nxt       = ST_FETCH;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                state_nxt      = (Opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (Mem_ready) begin
                    state_nxt = ST_MEM_WB;
                end else if (wait_hit) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_nxt       = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (Mem_ready || wait_hit) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_nxt      = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.branch_ne     = bne_flag;
                state_nxt          = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                state_nxt      = ST_FETCH;
            end
            ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                state_nxt      = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_nxt      = ST_FETCH;
            end
            default: begin
                ctrl      = ctrl_idle();
                state_nxt = ST_FETCH;
            end
        endcase
        ctrl.mem_timeout = wait_hit;
        // Strobes drop the moment RESET falls, not at the next edge.
        if (!RESET) begin
            ctrl = ctrl_idle();
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign Branch_ne   = ctrl.branch_ne;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign Illegal_op  = ctrl.illegal_op;
    assign Mem_timeout = ctrl.mem_timeout;
    assign State       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction-path model plus literal spot checks.
module tb_multicycle_control;

    localparam int WAIT_MAX = 15;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       CLK;
    logic       RESET;
    logic [5:0] Opcode;
    logic       Mem_ready;
    logic       PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal_op, Mem_timeout;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    multicycle_control dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Opcode      (Opcode),
        .Mem_ready   (Mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .Branch_ne   (Branch_ne),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .State       (State),
        .Illegal_op  (Illegal_op),
        .Mem_timeout (Mem_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       illegal_op, mem_timeout;
        logic [3:0] state;
    } obs_t;

    obs_t got;
    assign got = {PCWrite, PCWriteCond, Branch_ne, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                  Illegal_op, Mem_timeout, State};

    int         n_vec;
    int         n_bad;
    obs_t       hist[$];
    int         m_state, m_wait, m_len, m_pos;
    logic [11:0] m_path;
    logic       m_bne;

    // Remaining states after DECODE for each opcode: {length, s0, s1, s2}.
    function automatic logic [15:0] path_of(input logic [5:0] op);
        case (op)
            OP_R:    return {4'd2, 4'd6, 4'd7, 4'd0};
            OP_LW:   return {4'd3, 4'd2, 4'd3, 4'd4};
            OP_SW:   return {4'd2, 4'd2, 4'd5, 4'd0};
            OP_BEQ:  return {4'd1, 4'd8, 8'd0};
`ifdef MULTICYCLE_BNE_EN
            OP_BNE:  return {4'd1, 4'd8, 8'd0};
`endif
            OP_J:    return {4'd1, 4'd9, 8'd0};
            OP_ADDI: return {4'd2, 4'd10, 4'd11, 4'd0};
            default: return 16'd0;
        endcase
    endfunction

    function automatic obs_t state_outs(input int s);
        obs_t e;
        e = '0;
        e.state = 4'(s);
        case (s)
            0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; end
            1:  e.alu_src_b = 2'b11;
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.iord = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.mem_write = 1; e.iord = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            9:  begin e.pc_write = 1; e.pc_source = 2'b10; end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            11: e.reg_write = 1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic is_wait_state(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    function automatic obs_t expected(input logic [5:0] op, input logic rdy);
        obs_t        e;
        logic [15:0] p;
        if (!RESET) begin
            e = '0;
            e.alu_src_b = 2'b01;
            return e;
        end
        e = state_outs(m_state);
        if (is_wait_state(m_state) && !rdy && m_wait == WAIT_MAX - 1) e.mem_timeout = 1;
        if (m_state == 0 && rdy) begin
            e.ir_write = 1;
            e.pc_write = 1;
        end
        p = path_of(op);
        if (m_state == 1 && p[15:12] == 4'd0) e.illegal_op = 1;
`ifdef MULTICYCLE_BNE_EN
        if (m_state == 8) e.branch_ne = m_bne;
`endif
        return e;
    endfunction

    task automatic model_tick(input logic [5:0] op, input logic rdy);
        logic [15:0] p;
        if (!RESET) begin
            m_state = 0; m_wait = 0; m_len = 0; m_pos = 0;
            return;
        end
        if (is_wait_state(m_state) && !rdy) begin
            if (m_wait == WAIT_MAX - 1) begin
                m_state = 0; m_wait = 0; m_len = 0;
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                p      = path_of(op);
                m_len  = int'(p[15:12]);
                m_path = p[11:0];
                m_bne  = (op == OP_BNE);
                if (m_len == 0) m_state = 0;
                else begin
                    m_state = int'(p[11:8]);
                    m_pos   = 1;
                end
            end else if (m_pos < m_len) begin
                m_state = int'(m_path[11 - 4*m_pos -: 4]);
                m_pos++;
            end else begin
                m_state = 0;
            end
        end
    endtask

    task automatic check_obs(input string name, input obs_t e);
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h (state got %0d want %0d)",
                     name, $time, got, e, got.state, e.state);
        end
    endtask

    task automatic lit(input string name, input int g, input int w);
        n_vec++;
        if (g != w) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, g, w);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic step(input logic [5:0] op, input logic rdy);
        Opcode    = op;
        Mem_ready = rdy;
        @(negedge CLK);
        check_obs("cycle", expected(op, rdy));
        hist.push_back(got);
        @(posedge CLK);
        model_tick(op, rdy);
        #1;
    endtask

    // kind: 0 state==val, 1 mem_write, 2 reg_write, 3 pc_write, 4 mem_timeout, 5 pc_source==val
    function automatic int count(input int from, input int kind, input int val);
        int n;
        n = 0;
        for (int i = from; i < hist.size(); i++) begin
            case (kind)
                0: n += (int'(hist[i].state) == val) ? 1 : 0;
                1: n += int'(hist[i].mem_write);
                2: n += int'(hist[i].reg_write);
                3: n += int'(hist[i].pc_write);
                4: n += int'(hist[i].mem_timeout);
                default: n += (int'(hist[i].pc_source) == val) ? 1 : 0;
            endcase
        end
        return n;
    endfunction

    initial begin
        int b;
        n_vec = 0; n_bad = 0;
        m_state = 0; m_wait = 0; m_len = 0; m_pos = 0; m_path = '0; m_bne = 0;
        RESET = 1'b0; Opcode = OP_R; Mem_ready = 1'b0;
        #3;
        check_obs("reset", expected(OP_R, 1'b0));
        lit("reset_state", int'(State), 0);
        lit("reset_memread", int'(MemRead), 0);
        lit("reset_alusrcb", int'(ALUSrcB), 1);
        @(posedge CLK); #1;
        RESET = 1'b1;

        // R-type, Mem_ready ignored outside memory states
        b = hist.size();
        step(OP_R, 1); step(OP_R, 0); step(OP_R, 1); step(OP_R, 0);
        lit("r_s0", int'(hist[b].state), 0);
        lit("r_s1", int'(hist[b+1].state), 1);
        lit("r_s2", int'(hist[b+2].state), 6);
        lit("r_s3", int'(hist[b+3].state), 7);
        lit("r_end", int'(State), 0);
        lit("r_regwrite_cnt", count(b, 2, 0), 1);
        lit("r_regdst_s7", int'(hist[b+3].reg_dst), 1);

        // lw with three stall cycles in MEM_READ
        b = hist.size();
        step(OP_LW, 1); step(OP_LW, 1); step(OP_LW, 0);
        step(OP_LW, 0); step(OP_LW, 0); step(OP_LW, 0); step(OP_LW, 1);
        step(OP_LW, 1);
        lit("lw_memread_cycles", count(b, 0, 3), 4);
        lit("lw_memwrite_cnt", count(b, 1, 0), 0);
        lit("lw_wb_state", int'(hist[hist.size()-1].state), 4);
        lit("lw_end", int'(State), 0);

        // sw, beq, addi, j
        step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 1);
        lit("sw_end", int'(State), 0);
        step(OP_BEQ, 1); step(OP_BEQ, 1); step(OP_BEQ, 1);
        step(OP_ADDI, 1); step(OP_ADDI, 1); step(OP_ADDI, 1); step(OP_ADDI, 1);
        b = hist.size();
        step(OP_J, 1); step(OP_J, 1); step(OP_J, 0);
        lit("j_state", int'(hist[b+2].state), 9);
        lit("j_pcwrite", int'(hist[b+2].pc_write), 1);
        lit("j_pcsource_cnt", count(b, 5, 2), 1);
        lit("j_end", int'(State), 0);

        // unknown opcode
        b = hist.size();
        step(OP_BAD, 1); step(OP_BAD, 1);
        lit("bad_illegal", int'(hist[b+1].illegal_op), 1);
        lit("bad_end", int'(State), 0);

        // bne: illegal unless the option is built in
        b = hist.size();
        step(OP_BNE, 1); step(OP_BNE, 1);
`ifdef MULTICYCLE_BNE_EN
        lit("bne_state", int'(State), 8);
        step(OP_BNE, 0);
        lit("bne_flag", int'(hist[b+2].branch_ne), 1);
`else
        lit("bne_illegal", int'(hist[b+1].illegal_op), 1);
        lit("bne_end", int'(State), 0);
`endif

        // FETCH timeout on the 15th stalled cycle, counter restarts afterwards
        b = hist.size();
        for (int i = 0; i < 15; i++) step(OP_R, 0);
        lit("to_pulse", int'(hist[b+14].mem_timeout), 1);
        lit("to_pulse_cnt", count(b, 4, 0), 1);
        lit("to_pcwrite_cnt", count(b, 3, 0), 0);
        lit("to_end", int'(State), 0);
        b = hist.size();
        for (int i = 0; i < 14; i++) step(OP_R, 0);
        step(OP_R, 1);
        lit("ready_wins_to", count(b, 4, 0), 0);
        lit("ready_wins_ir", int'(hist[hist.size()-1].ir_write), 1);
        step(OP_R, 1); step(OP_R, 1); step(OP_R, 1);

        // timeout while stalled in MEM_READ
        step(OP_LW, 1); step(OP_LW, 1); step(OP_LW, 1);
        b = hist.size();
        for (int i = 0; i < 15; i++) step(OP_LW, 0);
        lit("mr_to_pulse", int'(hist[b+14].mem_timeout), 1);
        lit("mr_to_regwrite", count(b, 2, 0), 0);
        lit("mr_to_end", int'(State), 0);

        // asynchronous reset while MEM_WRITE is stalled
        step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 0); step(OP_SW, 0);
        Opcode = OP_SW; Mem_ready = 1'b0;
        #2 RESET = 1'b0;
        model_tick(OP_SW, 1'b0);
        #1;
        check_obs("async_reset", expected(OP_SW, 1'b0));
        lit("ar_state", int'(State), 0);
        lit("ar_memwrite", int'(MemWrite), 0);
        b = hist.size();
        step(OP_SW, 0); step(OP_SW, 1);
        RESET = 1'b1;
        step(OP_SW, 1); step(OP_SW, 1); step(OP_SW, 0);
        lit("ar_no_memwrite", count(b, 1, 0), 0);
        step(OP_SW, 1);
        lit("ar_sw_end", int'(State), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
